// File: rtl/mem_stage_cache_if.sv
// Main-memory bus between the MEM-stage data cache and the slow backing memory.
//   mem_req   : request held high until mem_ready
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned byte address
//   mem_wdata : write data
//   mem_rdata : read data, valid together with mem_ready
//   mem_ready : one-cycle completion pulse
// master = cache side, slave = memory side.
interface mem_stage_cache_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_stage_cache.sv
// MEM pipeline stage with a direct-mapped, write-back, write-allocate data cache
// of LINES one-word lines. Misses and dirty evictions go to main memory over the
// mem_bus handshake; a halt request flushes every dirty line before flush_done.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   ALU_result            load/store byte address, or ALU value for writeback
//   rt_data_in            store data
//   rd_num_in             destination register from EX
//   register_write_in     instruction writes the register file
//   register_src_in       00 ALU, 01 load, 10 link (inst_addr_in+8), 11 ALU
//   we_cache_in           store instruction
//   is_word_in            1 = word access, 0 = byte access
//   inst_addr_in          PC of the instruction
//   halted_in             level request to flush dirty lines
//   stall                 freeze upstream stages and hold this stage's inputs
//   wb_data, wb_rd_num,
//   wb_register_write     registered MEM/WB outputs
//   flush_done            high once the halt flush has completed
//   mem_bus               main-memory request/ready bus (master side)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | serve hits, detect misses and halt requests
// ST_WRITEBACK| write the dirty victim line back before refilling
// ST_REFILL   | read the missing word into the indexed line
// ST_FLUSH_SCAN| look at line ptr_q; dirty -> write it back, else advance
// ST_FLUSH_WB | write back line ptr_q, then clear its dirty bit
// ST_HALTED   | flush complete; terminal until reset
module mem_stage_cache #(
    parameter int LINES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_result,
    input  logic [31:0] rt_data_in,
    input  logic [4:0]  rd_num_in,
    input  logic        register_write_in,
    input  logic [1:0]  register_src_in,
    input  logic        we_cache_in,
    input  logic        is_word_in,
    input  logic [31:0] inst_addr_in,
    input  logic        halted_in,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd_num,
    output logic        wb_register_write,
    output logic        flush_done,
    mem_stage_cache_if.master mem_bus
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_REFILL,
        ST_FLUSH_SCAN,
        ST_FLUSH_WB,
        ST_HALTED
    } state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       lane;
    logic             is_load;
    logic             access;
    logic             hit;
    logic             idle;

    logic [31:0] line_word;
    logic [7:0]  load_byte;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic [31:0] wb_sel;

    logic        fill_en;
    logic        store_en;
    logic        flush_clr;

    assign idx     = ALU_result[IDX_W+1:2];
    assign tag     = ALU_result[31:IDX_W+2];
    assign lane    = ALU_result[1:0];
    assign is_load = (register_src_in == 2'b01);
    assign access  = we_cache_in | is_load;
    assign hit     = valid_q[idx] & (tag_q[idx] == tag);
    assign idle    = (state_q == ST_IDLE);

    assign stall = ~idle | (access & ~hit & idle) | (halted_in & idle);

    // Little-endian byte lanes; byte loads sign-extend.
    always_comb begin
        line_word = data_q[idx];
        load_byte = line_word[7:0];
        case (lane)
            2'd0: load_byte = line_word[7:0];
            2'd1: load_byte = line_word[15:8];
            2'd2: load_byte = line_word[23:16];
            2'd3: load_byte = line_word[31:24];
            default: load_byte = line_word[7:0];
        endcase
        load_data = is_word_in ? line_word : {{24{load_byte[7]}}, load_byte};
    end

    always_comb begin
        store_word = line_word;
        if (is_word_in) begin
            store_word = rt_data_in;
        end else begin
            case (lane)
                2'd0: store_word[7:0]   = rt_data_in[7:0];
                2'd1: store_word[15:8]  = rt_data_in[7:0];
                2'd2: store_word[23:16] = rt_data_in[7:0];
                2'd3: store_word[31:24] = rt_data_in[7:0];
                default: store_word = line_word;
            endcase
        end
    end

    always_comb begin
        case (register_src_in)
            2'b01:   wb_sel = load_data;
            2'b10:   wb_sel = inst_addr_in + 32'd8;
            default: wb_sel = ALU_result;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        ptr_d              = ptr_q;
        fill_en            = 1'b0;
        store_en           = 1'b0;
        flush_clr          = 1'b0;
        flush_done         = 1'b0;
        mem_bus.mem_req    = 1'b0;
        mem_bus.mem_we     = 1'b0;
        mem_bus.mem_addr   = 32'd0;
        mem_bus.mem_wdata  = 32'd0;

        case (state_q)
            ST_IDLE: begin
                // Halt wins over an access presented in the same cycle.
                if (halted_in) begin
                    state_d = ST_FLUSH_SCAN;
                    ptr_d   = '0;
                end else if (access) begin
                    if (hit) begin
                        store_en = we_cache_in;
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem_bus.mem_req   = 1'b1;
                mem_bus.mem_we    = 1'b1;
                mem_bus.mem_addr  = {tag_q[idx], idx, 2'b00};
                mem_bus.mem_wdata = data_q[idx];
                if (mem_bus.mem_ready) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_bus.mem_req  = 1'b1;
                mem_bus.mem_addr = {ALU_result[31:2], 2'b00};
                if (mem_bus.mem_ready) begin
                    fill_en = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH_SCAN: begin
                if (dirty_q[ptr_q]) begin
                    state_d = ST_FLUSH_WB;
                end else if (ptr_q == IDX_W'(LINES - 1)) begin
                    state_d = ST_HALTED;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            ST_FLUSH_WB: begin
                mem_bus.mem_req   = 1'b1;
                mem_bus.mem_we    = 1'b1;
                mem_bus.mem_addr  = {tag_q[ptr_q], ptr_q, 2'b00};
                mem_bus.mem_wdata = data_q[ptr_q];
                // Back to scan with the same pointer; the now-clean line advances it.
                if (mem_bus.mem_ready) begin
                    flush_clr = 1'b1;
                    state_d   = ST_FLUSH_SCAN;
                end
            end
            ST_HALTED: begin
                flush_done = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (fill_en) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
                tag_q[idx]   <= tag;
            end
            if (store_en) begin
                dirty_q[idx] <= 1'b1;
            end
            if (flush_clr) begin
                dirty_q[ptr_q] <= 1'b0;
            end
        end
    end

    // Data array has no reset; valid bits gate every use of its contents.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[idx] <= mem_bus.mem_rdata;
        end else if (store_en) begin
            data_q[idx] <= store_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data           <= 32'd0;
            wb_rd_num         <= 5'd0;
            wb_register_write <= 1'b0;
        end else if (!stall) begin
            wb_data           <= wb_sel;
            wb_rd_num         <= rd_num_in;
            wb_register_write <= register_write_in;
        end else begin
            wb_register_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_cache.sv
`timescale 1ns/1ps
module tb_mem_stage_cache;
    localparam int LINES = 8;
    localparam int IDX_W = 3;

    // op kinds
    localparam int K_ALU = 0, K_LW = 1, K_LB = 2, K_SW = 3, K_SB = 4, K_LINK = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALU_result, rt_data_in, inst_addr_in;
    logic [4:0]  rd_num_in;
    logic        register_write_in;
    logic [1:0]  register_src_in;
    logic        we_cache_in, is_word_in, halted_in;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_num;
    logic        wb_register_write, flush_done;

    mem_stage_cache_if mem_if();

    mem_stage_cache #(.LINES(LINES)) dut (
        .clk(clk), .reset(reset),
        .ALU_result(ALU_result), .rt_data_in(rt_data_in), .rd_num_in(rd_num_in),
        .register_write_in(register_write_in), .register_src_in(register_src_in),
        .we_cache_in(we_cache_in), .is_word_in(is_word_in), .inst_addr_in(inst_addr_in),
        .halted_in(halted_in), .stall(stall), .wb_data(wb_data), .wb_rd_num(wb_rd_num),
        .wb_register_write(wb_register_write), .flush_done(flush_done),
        .mem_bus(mem_if)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- main memory responder ----------------
    bit resp_en = 1'b1;
    int rd_lat = 3;
    int wb_lat = 2;
    int resp_cnt = 0;
    logic [31:0] world [logic [31:0]];
    logic        log_we [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_C3C3;
    endfunction

    initial begin
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (reset || !mem_if.mem_req) begin
                    mem_if.mem_ready = 1'b0;
                    resp_cnt = 0;
                end else if (resp_cnt == (mem_if.mem_we ? wb_lat : rd_lat) - 1) begin
                    mem_if.mem_ready = 1'b1;
                    resp_cnt = 0;
                    log_we.push_back(mem_if.mem_we);
                    log_addr.push_back(mem_if.mem_addr);
                    log_data.push_back(mem_if.mem_wdata);
                    if (mem_if.mem_we)
                        world[mem_if.mem_addr] = mem_if.mem_wdata;
                    else
                        mem_if.mem_rdata = world.exists(mem_if.mem_addr) ?
                                           world[mem_if.mem_addr] : init_word(mem_if.mem_addr);
                end else begin
                    mem_if.mem_ready = 1'b0;
                    resp_cnt++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Flat coherent memory gives every load value; a tag/dirty table only
    // predicts which memory transfers a write-back cache must perform.
    logic [31:0] ref_mem [logic [31:0]];
    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    logic [31:0] m_tag   [LINES];
    logic        ex_we [$];
    logic [31:0] ex_addr [$];
    logic [31:0] ex_data [$];

    function automatic logic [31:0] ref_word(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0;
        end
        ref_mem = world;
    endtask

    task automatic model_op(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] ia, output int exp_stall,
                            output logic [31:0] exp_wb);
        logic [31:0] wa, va, word;
        logic [7:0]  b;
        int          idx;
        logic [31:0] tg;
        wa = {addr[31:2], 2'b00};
        idx = int'((addr >> 2) % LINES);
        tg = addr >> (2 + IDX_W);
        exp_stall = 0;
        exp_wb = addr;
        ex_we.delete(); ex_addr.delete(); ex_data.delete();
        if (kind >= K_LW && kind <= K_SB) begin
            if (!(m_valid[idx] && m_tag[idx] == tg)) begin
                exp_stall = 1 + rd_lat;
                if (m_valid[idx] && m_dirty[idx]) begin
                    va = (m_tag[idx] << (2 + IDX_W)) | (idx << 2);
                    ex_we.push_back(1'b1); ex_addr.push_back(va); ex_data.push_back(ref_word(va));
                    exp_stall += wb_lat;
                end
                ex_we.push_back(1'b0); ex_addr.push_back(wa); ex_data.push_back(32'd0);
                m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0;
            end
            word = ref_word(wa);
            case (kind)
                K_LW: exp_wb = word;
                K_LB: begin
                    b = 8'(word >> (8 * addr[1:0]));
                    exp_wb = {{24{b[7]}}, b};
                end
                K_SW: begin ref_mem[wa] = wd; m_dirty[idx] = 1; end
                default: begin
                    word[8*addr[1:0] +: 8] = wd[7:0];
                    ref_mem[wa] = word; m_dirty[idx] = 1;
                end
            endcase
        end else if (kind == K_LINK) begin
            exp_wb = ia + 32'd8;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        we_cache_in = 1'b0; register_src_in = 2'b00; register_write_in = 1'b0;
        is_word_in = 1'b1; rd_num_in = 5'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; drive_idle(); halted_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Presents one instruction, waits out the stall, returns the MEM/WB result.
    task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] ia,
                         output int stall_cycles, output bit bubble_bad, output bit timeout);
        @(negedge clk);
        ALU_result = addr; rt_data_in = wd; rd_num_in = rd; inst_addr_in = ia;
        we_cache_in = (kind == K_SW || kind == K_SB);
        is_word_in = !(kind == K_LB || kind == K_SB);
        register_write_in = !(kind == K_SW || kind == K_SB);
        case (kind)
            K_LW, K_LB: register_src_in = 2'b01;
            K_LINK:     register_src_in = 2'b10;
            default:    register_src_in = 2'b00;
        endcase
        #1;
        stall_cycles = 0; bubble_bad = 0; timeout = 0;
        while (stall === 1'b1) begin
            if (stall_cycles >= 100) begin timeout = 1; break; end
            @(posedge clk); #1;
            stall_cycles++;
            if (wb_register_write !== 1'b0) bubble_bad = 1;
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; drive_idle(); halted_in = 1'b0;
        ALU_result = 32'd0; rt_data_in = 32'd0; inst_addr_in = 32'd0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({mem_if.mem_req, mem_if.mem_we, flush_done, wb_register_write} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: req/we/flush_done/wb_rw=%b expected 0000",
                     {mem_if.mem_req, mem_if.mem_we, flush_done, wb_register_write});
        end
        tests_run++;
        if (wb_data !== 32'd0 || wb_rd_num !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_wb: wb_data=%h rd=%0d expected 0/0", wb_data, wb_rd_num);
        end
        reset = 1'b0;
        model_clear();
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stall: stall=%b expected 0", stall);
        end
    endtask

    task automatic test_clean_miss();
        int sc, es; bit bb, to; int mark; logic [31:0] ew;
        world[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;
        rd_lat = 3;
        mark = log_addr.size();
        model_op(K_LW, 32'h40, 32'd0, 32'd0, es, ew);
        do_op(K_LW, 32'h40, 32'd0, 5'd3, 32'd0, sc, bb, to);
        tests_run++;
        if (to || sc != 4) begin
            tests_failed++;
            $display("FAIL miss_stall: stall cycles=%0d timeout=%0d expected 4", sc, to);
        end
        tests_run++;
        if (wb_data !== 32'hDEADBEEF || wb_rd_num !== 5'd3 || wb_register_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL miss_wb: data=%h rd=%0d rw=%b expected deadbeef/3/1",
                     wb_data, wb_rd_num, wb_register_write);
        end
        tests_run++;
        if (bb) begin
            tests_failed++;
            $display("FAIL miss_bubble: wb_register_write was 1 during stall, expected 0");
        end
        tests_run++;
        if (log_addr.size() != mark + 1 || log_we[mark] !== 1'b0 || log_addr[mark] !== 32'h40) begin
            tests_failed++;
            $display("FAIL miss_req: %0d transfers, expected one read of 00000040",
                     log_addr.size() - mark);
        end
    endtask

    task automatic test_byte_store_load();
        int sc, es; bit bb, to; int mark; logic [31:0] ew;
        mark = log_addr.size();
        model_op(K_SB, 32'h41, 32'h80, 32'd0, es, ew);
        do_op(K_SB, 32'h41, 32'h80, 5'd0, 32'd0, sc, bb, to);
        tests_run++;
        if (sc != 0) begin
            tests_failed++;
            $display("FAIL sb_hit_stall: stall cycles=%0d expected 0", sc);
        end
        model_op(K_LB, 32'h41, 32'd0, 32'd0, es, ew);
        do_op(K_LB, 32'h41, 32'd0, 5'd4, 32'd0, sc, bb, to);
        tests_run++;
        if (sc != 0 || wb_data !== 32'hFFFF_FF80) begin
            tests_failed++;
            $display("FAIL lb_hit: data=%h stall=%0d expected ffffff80/0", wb_data, sc);
        end
        model_op(K_LW, 32'h40, 32'd0, 32'd0, es, ew);
        do_op(K_LW, 32'h40, 32'd0, 5'd5, 32'd0, sc, bb, to);
        tests_run++;
        if (sc != 0 || wb_data !== 32'hDEAD_80EF) begin
            tests_failed++;
            $display("FAIL lw_merged: data=%h stall=%0d expected dead80ef/0", wb_data, sc);
        end
        tests_run++;
        if (log_addr.size() != mark) begin
            tests_failed++;
            $display("FAIL hit_no_req: %0d transfers expected 0", log_addr.size() - mark);
        end
    endtask

    task automatic test_dirty_miss();
        int sc, es; bit bb, to; int mark; logic [31:0] ew;
        world[32'h60] = 32'h1234_5678;
        ref_mem[32'h60] = 32'h1234_5678;
        wb_lat = 2; rd_lat = 3;
        mark = log_addr.size();
        model_op(K_LW, 32'h60, 32'd0, 32'd0, es, ew);
        do_op(K_LW, 32'h60, 32'd0, 5'd6, 32'd0, sc, bb, to);
        tests_run++;
        if (to || sc != 6) begin
            tests_failed++;
            $display("FAIL dirty_stall: stall cycles=%0d expected 6", sc);
        end
        tests_run++;
        if (log_addr.size() != mark + 2) begin
            tests_failed++;
            $display("FAIL dirty_count: %0d transfers expected 2", log_addr.size() - mark);
        end else begin
            tests_run++;
            if (log_we[mark] !== 1'b1 || log_addr[mark] !== 32'h40 || log_data[mark] !== 32'hDEAD80EF) begin
                tests_failed++;
                $display("FAIL dirty_wb: we=%b addr=%h data=%h expected 1/00000040/dead80ef",
                         log_we[mark], log_addr[mark], log_data[mark]);
            end
            tests_run++;
            if (log_we[mark+1] !== 1'b0 || log_addr[mark+1] !== 32'h60) begin
                tests_failed++;
                $display("FAIL dirty_refill: we=%b addr=%h expected 0/00000060",
                         log_we[mark+1], log_addr[mark+1]);
            end
        end
        tests_run++;
        if (wb_data !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL dirty_data: data=%h expected 12345678", wb_data);
        end
    endtask

    task automatic test_alu_link();
        int sc; bit bb, to;
        do_op(K_ALU, 32'd5, 32'd0, 5'd9, 32'd0, sc, bb, to);
        tests_run++;
        if (sc != 0 || wb_data !== 32'd5 || wb_rd_num !== 5'd9 || wb_register_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL alu_op: stall=%0d data=%h rd=%0d rw=%b expected 0/5/9/1",
                     sc, wb_data, wb_rd_num, wb_register_write);
        end
        do_op(K_LINK, 32'd7, 32'd0, 5'd31, 32'h100, sc, bb, to);
        tests_run++;
        if (sc != 0 || wb_data !== 32'h108 || wb_rd_num !== 5'd31) begin
            tests_failed++;
            $display("FAIL link_op: stall=%0d data=%h rd=%0d expected 0/108/31",
                     sc, wb_data, wb_rd_num);
        end
        #0;
        tests_run++;
        if (wb_register_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL link_rw: rw=%b expected 1", wb_register_write);
        end
        @(posedge clk); #1;
        tests_run++;
        if (wb_register_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_rw: rw=%b expected 0 after idle cycle", wb_register_write);
        end
    endtask

    task automatic test_random();
        int kind, sc, es, mark; bit bb, to;
        logic [31:0] a, wd, ia, ew; logic [4:0] rd;
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 5);
            a = 32'($urandom_range(0, 63)) << 2;
            if (kind == K_LB || kind == K_SB) a = a | 32'($urandom_range(0, 3));
            wd = $urandom; ia = $urandom & 32'hFFFC;
            rd = 5'($urandom_range(1, 31));
            rd_lat = $urandom_range(1, 4); wb_lat = $urandom_range(1, 4);
            mark = log_addr.size();
            model_op(kind, a, wd, ia, es, ew);
            do_op(kind, a, wd, rd, ia, sc, bb, to);
            tests_run++;
            if (to || sc != es || bb) begin
                tests_failed++;
                $display("FAIL rnd_stall[%0d]: kind=%0d addr=%h stall=%0d bubble_err=%0d expected %0d",
                         n, kind, a, sc, bb, es);
            end
            tests_run++;
            if (wb_data !== ew || wb_rd_num !== rd ||
                wb_register_write !== !(kind == K_SW || kind == K_SB)) begin
                tests_failed++;
                $display("FAIL rnd_wb[%0d]: kind=%0d addr=%h data=%h rd=%0d rw=%b expected %h/%0d",
                         n, kind, a, wb_data, wb_rd_num, wb_register_write, ew, rd);
            end
            tests_run++;
            if (log_addr.size() != mark + ex_addr.size()) begin
                tests_failed++;
                $display("FAIL rnd_xfers[%0d]: %0d transfers expected %0d",
                         n, log_addr.size() - mark, ex_addr.size());
            end else begin
                for (int k = 0; k < ex_addr.size(); k++) begin
                    tests_run++;
                    if (log_we[mark+k] !== ex_we[k] || log_addr[mark+k] !== ex_addr[k] ||
                        (ex_we[k] && log_data[mark+k] !== ex_data[k])) begin
                        tests_failed++;
                        $display("FAIL rnd_xfer[%0d.%0d]: we=%b addr=%h data=%h expected %b/%h/%h",
                                 n, k, log_we[mark+k], log_addr[mark+k], log_data[mark+k],
                                 ex_we[k], ex_addr[k], ex_data[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_halt_flush();
        int sc, es, mark, cyc; bit bb, to, bad; logic [31:0] ew;
        apply_reset();
        wb_lat = 2; rd_lat = 2;
        model_op(K_SW, 32'h48, 32'hA1A2A3A4, 32'd0, es, ew);
        do_op(K_SW, 32'h48, 32'hA1A2A3A4, 5'd0, 32'd0, sc, bb, to);
        model_op(K_SW, 32'h54, 32'hB1B2B3B4, 32'd0, es, ew);
        do_op(K_SW, 32'h54, 32'hB1B2B3B4, 5'd0, 32'd0, sc, bb, to);
        model_op(K_LW, 32'h0C, 32'd0, 32'd0, es, ew);
        do_op(K_LW, 32'h0C, 32'd0, 5'd2, 32'd0, sc, bb, to);
        mark = log_addr.size();
        @(negedge clk);
        halted_in = 1'b1;
        ALU_result = 32'h80; register_src_in = 2'b01; register_write_in = 1'b1; rd_num_in = 5'd7;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_stall0: stall=%b expected 1", stall);
        end
        cyc = 0; bad = 0;
        while (flush_done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (stall !== 1'b1 || wb_register_write !== 1'b0) bad = 1;
        end
        tests_run++;
        if (flush_done !== 1'b1 || bad) begin
            tests_failed++;
            $display("FAIL halt_done: flush_done=%b stall_err=%0d after %0d cycles expected 1/0",
                     flush_done, bad, cyc);
        end
        tests_run++;
        if (log_addr.size() != mark + 2) begin
            tests_failed++;
            $display("FAIL halt_count: %0d transfers expected 2", log_addr.size() - mark);
        end else begin
            tests_run++;
            if (log_we[mark] !== 1'b1 || log_addr[mark] !== 32'h48 || log_data[mark] !== 32'hA1A2A3A4 ||
                log_we[mark+1] !== 1'b1 || log_addr[mark+1] !== 32'h54 || log_data[mark+1] !== 32'hB1B2B3B4) begin
                tests_failed++;
                $display("FAIL halt_order: %h=%h then %h=%h expected 00000048=a1a2a3a4 then 00000054=b1b2b3b4",
                         log_addr[mark], log_data[mark], log_addr[mark+1], log_data[mark+1]);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (flush_done !== 1'b1 || stall !== 1'b1 || mem_if.mem_req !== 1'b0 || log_addr.size() != mark + 2) begin
            tests_failed++;
            $display("FAIL halt_terminal: flush_done=%b stall=%b req=%b xfers=%0d expected 1/1/0/2",
                     flush_done, stall, mem_if.mem_req, log_addr.size() - mark);
        end
    endtask

    task automatic test_reset_mid_refill();
        int sc, es, mark; bit bb, to; logic [31:0] ew;
        apply_reset();
        resp_en = 1'b0;
        mem_if.mem_ready = 1'b0;
        @(negedge clk);
        ALU_result = 32'h40; register_src_in = 2'b01; is_word_in = 1'b1;
        register_write_in = 1'b1; rd_num_in = 5'd8;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b0 || mem_if.mem_addr !== 32'h40) begin
            tests_failed++;
            $display("FAIL refill_req: req=%b we=%b addr=%h expected 1/0/00000040",
                     mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (mem_if.mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req_drop: req=%b expected 0", mem_if.mem_req);
        end
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        mem_if.mem_ready = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0 || mem_if.mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_ready: stall=%b req=%b expected 0/0", stall, mem_if.mem_req);
        end
        resp_en = 1'b1;
        rd_lat = 2;
        mark = log_addr.size();
        model_op(K_LW, 32'h40, 32'd0, 32'd0, es, ew);
        do_op(K_LW, 32'h40, 32'd0, 5'd8, 32'd0, sc, bb, to);
        tests_run++;
        if (to || sc != 3 || log_addr.size() != mark + 1 || wb_data !== ew) begin
            tests_failed++;
            $display("FAIL re_miss: stall=%0d xfers=%0d data=%h expected 3/1/%h",
                     sc, log_addr.size() - mark, wb_data, ew);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_miss();
        test_byte_store_load();
        test_dirty_miss();
        test_alu_link();
        test_random();
        test_halt_flush();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_stage_cache.md
Name: mem_stage_cache

Overview:
- Consumer side of the EX→MEM pipeline boundary. Takes EX's ALU_result, rd_num and store data, plus the cache and memory control bits that travel with them.
- Performs the load/store through a direct-mapped, write-back, write-allocate data cache. Misses and writebacks go to a slow main memory over a req/ready handshake.
- Drives the registered MEM/WB outputs and a pipeline stall.
- On halt, flushes all dirty lines before reporting flush_done.

Parameters:
- LINES, 8, number of one-word cache lines (power of 2, ≥2); IDX_W = log2(LINES).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ALU_result  in  32  byte address for loads/stores; also the ALU value for writeback
- rt_data_in  in  32  store data
- rd_num_in  in  5  destination register from EX
- register_write_in  in  1  instruction writes the register file
- register_src_in  in  2  00 = ALU result, 01 = memory load, 10 = inst_addr_in+8 (link)
- we_cache_in  in  1  store instruction
- is_word_in  in  1  1 = word access, 0 = byte access
- inst_addr_in  in  32  PC of the instruction
- halted_in  in  1  level; request a flush of dirty lines
- stall  out  1  freeze IF/ID/EX and hold this stage's inputs
- wb_data  out  32  registered writeback value
- wb_rd_num  out  5  registered destination register
- wb_register_write  out  1  registered write enable
- flush_done  out  1  high once the halt flush is complete
- mem_req  out  1  main-memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion pulse

Behaviour:
- Address fields:
  - index = ALU_result[IDX_W+1:2]
  - tag = ALU_result[31:IDX_W+2]
  - byte lane = ALU_result[1:0], little-endian
- Each line holds valid, dirty, tag and data.
- access = we_cache_in | (register_src_in==01).
- hit = valid[index] & (tag match).
- States: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB, HALTED.
- stall is combinational: (state≠IDLE) | (access & ~hit & state==IDLE) | (halted_in & state==IDLE).
- IDLE, access & hit (0 extra cycles):
  - Loads: word, or byte sign-extended from its lane.
  - Stores: write the word or merge the byte at the clock edge; set dirty=1.
- IDLE, access & miss:
  - Victim valid & dirty → WRITEBACK.
  - Otherwise → REFILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, 00}, mem_wdata = line data.
  - On mem_ready → REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {ALU_result[31:2], 00}.
  - On mem_ready: line ← mem_rdata, valid=1, dirty=0, tag written → IDLE.
  - Back in IDLE the held access re-evaluates as a hit and completes.
- mem_req stays asserted and address/data stay stable until mem_ready. mem_ready is ignored in IDLE.
- MEM/WB register updates every cycle:
  - stall=0: capture rd_num_in, register_write_in, and the data selected by register_src_in. Register_src 11 selects the ALU value.
  - stall=1: wb_register_write←0 (bubble); wb_data and wb_rd_num hold.
- Halt handling:
  - halted_in in IDLE → FLUSH_SCAN with scan pointer 0. An access in the same cycle is dropped; halt has priority.
  - FLUSH_SCAN: one cycle per line. If the line is dirty → FLUSH_WB (same handshake as WRITEBACK, then clear dirty, return to FLUSH_SCAN). Otherwise increment the pointer.
  - After the pointer reaches LINES-1 and that line is handled → HALTED.
  - HALTED: flush_done=1, stall=1; the state is terminal until reset.
- Reset (async, any state, including mid-handshake):
  - Valid, dirty and tags are cleared; state=IDLE; pointer=0.
  - mem_req, mem_we, wb_register_write and flush_done are 0; wb_data=0, wb_rd_num=0.
  - Data array contents are don't-care.
  - mem_req drops immediately; an in-flight mem_ready arriving after reset is ignored.
- Miss cost:
  - Clean miss: stall for 1 + refill latency cycles.
  - Dirty miss: adds the writeback latency.

Test Plan:
1. Reset, then load word at 0x40 with memory returning 0xDEADBEEF after 3 cycles → mem_req with mem_addr=0x40, mem_we=0; stall for 4 cycles; wb_data=0xDEADBEEF the cycle after stall drops; wb_register_write=0 during the stall.
2. Store byte 0x80 to 0x41, then load byte 0x41 and load word 0x40 → no mem_req; byte load gives 0xFFFFFF80; word load gives 0xDEAD80EF.
3. With LINES=8, load 0x60, which maps to the same index as dirty 0x40 → WRITEBACK writes 0xDEAD80EF at 0x40, then REFILL reads 0x60; total stall = 1 + writeback + refill latency.
4. ALU op with register_src_in=00, ALU_result=5, rd=9 → no stall; next cycle wb_data=5, wb_rd_num=9, wb_register_write=1. Link with register_src_in=10, inst_addr_in=0x100 → wb_data=0x108, rd=31.
5. Lines 2 and 5 dirty, assert halted_in → exactly two memory writes, in index order 2 then 5; flush_done rises after the last line; stall stays high.
6. Assert reset while REFILL is waiting for mem_ready → mem_req=0 immediately; the next access to the same address misses again.
